accum_shift_reg: RTL and testbench

//   Parametrised successor of the multiplier's 16-bit product register: a WIDTH-bit register with

---
 rtl/accum_shift_reg_pkg.sv | 11 +
 rtl/accum_shift_reg_shl_barrel.sv | 26 ++
 rtl/accum_shift_reg.sv | 134 +++++++++++++
 tb/tb_accum_shift_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_shift_reg_pkg.sv
// Package: accum_shift_reg_pkg
// Shared definitions for the product register and the multiplier FSM that drives it.
//   MODE_HOLD / MODE_LOAD / MODE_ACCUM / MODE_SHIFT : 2-bit mode encodings.
package accum_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_ACCUM = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

endpackage

// File: rtl/accum_shift_reg_shl_barrel.sv
// Module: shl_barrel
// Combinational logical left shifter. The input is zero-extended to OUT_W bits before the shift,
// so OUT_W must be large enough to keep every shifted-out bit the caller cares about.
// Ports:
//   din   in  IN_W     value to shift
//   shamt in  SHIFT_W  left-shift amount
//   dout  out OUT_W    zext(din) << shamt, zero fill
module shl_barrel #(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned OUT_W   = 33,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic [IN_W-1:0]    din,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [OUT_W-1:0]   dout
);

    logic [OUT_W-1:0] din_ext;

    always_comb begin
        din_ext            = '0;
        din_ext[IN_W-1:0]  = din;
        dout               = din_ext << shamt;
    end

endmodule

// File: rtl/accum_shift_reg.sv
// Module: accum_shift_reg
// Product register of the sequential multiplier: WIDTH-bit register with hold, load, shifted
// accumulate and shift modes, a sticky overflow flag and a saturating term counter.
// Ports:
//   clk      in   rising-edge clock
//   sclr     in   synchronous active-high clear (highest priority)
//   clk_ena  in   update enable; 0 holds all state
//   mode     in   00 HOLD, 01 LOAD, 10 ACCUM, 11 SHIFT
//   shamt    in   left-shift amount for ACCUM (datain) and SHIFT (register)
//   datain   in   operand for LOAD / ACCUM, zero-extended to WIDTH
//   reg_out  out  register contents
//   ovf      out  sticky overflow since last LOAD
//   term_cnt out  terms absorbed since last LOAD, saturates at NUM_TERMS
//   done     out  term_cnt == NUM_TERMS
module accum_shift_reg
    import accum_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned SHIFT_W   = 4,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned NUM_TERMS = 4,
    localparam int unsigned CNT_W    = $clog2(NUM_TERMS + 1)
) (
    input  logic                clk,
    input  logic                sclr,
    input  logic                clk_ena,
    input  logic [1:0]          mode,
    input  logic [SHIFT_W-1:0]  shamt,
    input  logic [IN_WIDTH-1:0] datain,
    output logic [WIDTH-1:0]    reg_out,
    output logic                ovf,
    output logic [CNT_W-1:0]    term_cnt,
    output logic                done
);

    // Wide enough that neither the max shift nor the accumulate carry can be lost.
    localparam int unsigned EXT_W = WIDTH + 2**SHIFT_W + 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(NUM_TERMS);

    logic [WIDTH-1:0] reg_q, reg_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] load_val;
    logic [EXT_W-1:0] reg_ext;
    logic [EXT_W-1:0] acc_operand;
    logic [EXT_W-1:0] reg_shifted;
    logic [EXT_W-1:0] sum;
    logic             acc_ovf;
    logic             shift_ovf;

    shl_barrel #(
        .IN_W    (IN_WIDTH),
        .OUT_W   (EXT_W),
        .SHIFT_W (SHIFT_W)
    ) u_shl_acc (
        .din   (datain),
        .shamt (shamt),
        .dout  (acc_operand)
    );

    shl_barrel #(
        .IN_W    (WIDTH),
        .OUT_W   (EXT_W),
        .SHIFT_W (SHIFT_W)
    ) u_shl_reg (
        .din   (reg_q),
        .shamt (shamt),
        .dout  (reg_shifted)
    );

    always_comb begin
        load_val                 = '0;
        load_val[IN_WIDTH-1:0]   = datain;
        reg_ext                  = '0;
        reg_ext[WIDTH-1:0]       = reg_q;
        sum                      = reg_ext + acc_operand;
        acc_ovf                  = |sum[EXT_W-1:WIDTH];
        // Anything left above WIDTH-1 after the shift was a nonzero bit pushed out.
        shift_ovf                = |reg_shifted[EXT_W-1:WIDTH];
    end

    always_comb begin
        reg_d = reg_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        case (mode)
            MODE_LOAD: begin
                reg_d = load_val;
                ovf_d = 1'b0;
                cnt_d = CNT_W'(1);
            end
            MODE_ACCUM: begin
                if (acc_ovf) begin
                    ovf_d = 1'b1;
                    reg_d = SATURATE ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                end else begin
                    reg_d = sum[WIDTH-1:0];
                end
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MODE_SHIFT: begin
                reg_d = reg_shifted[WIDTH-1:0];
                if (shift_ovf) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                // HOLD keeps everything.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            reg_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (clk_ena) begin
            reg_q <= reg_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign reg_out  = reg_q;
    assign ovf      = ovf_q;
    assign term_cnt = cnt_q;
    assign done     = (cnt_q == CntMax);

endmodule

// File: tb/tb_accum_shift_reg.sv
module tb_accum_shift_reg;

    logic        clk;
    logic        sclr;
    logic        clk_ena;
    logic [1:0]  mode;
    logic [3:0]  shamt;
    logic [15:0] datain;

    // Instance A: wrap, NUM_TERMS=4. Instance B: saturate, NUM_TERMS=2. Same stimulus.
    logic [15:0] reg_a, reg_b;
    logic        ovf_a, ovf_b;
    logic [2:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic        done_a, done_b;

    accum_shift_reg #(
        .WIDTH     (16),
        .IN_WIDTH  (16),
        .SHIFT_W   (4),
        .SATURATE  (1'b0),
        .NUM_TERMS (4)
    ) dut_a (
        .clk      (clk),
        .sclr     (sclr),
        .clk_ena  (clk_ena),
        .mode     (mode),
        .shamt    (shamt),
        .datain   (datain),
        .reg_out  (reg_a),
        .ovf      (ovf_a),
        .term_cnt (cnt_a),
        .done     (done_a)
    );

    accum_shift_reg #(
        .WIDTH     (16),
        .IN_WIDTH  (16),
        .SHIFT_W   (4),
        .SATURATE  (1'b1),
        .NUM_TERMS (2)
    ) dut_b (
        .clk      (clk),
        .sclr     (sclr),
        .clk_ena  (clk_ena),
        .mode     (mode),
        .shamt    (shamt),
        .datain   (datain),
        .reg_out  (reg_b),
        .ovf      (ovf_b),
        .term_cnt (cnt_b),
        .done     (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integer arithmetic on the register value.
    longint m_reg [2];
    int     m_ovf [2];
    int     m_cnt [2];
    int     m_nt  [2] = '{4, 2};
    int     m_sat [2] = '{0, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic s, input logic e, input logic [1:0] m,
                                input logic [3:0] sh, input logic [15:0] d);
        longint v;
        for (int i = 0; i < 2; i++) begin
            if (s) begin
                m_reg[i] = 0;
                m_ovf[i] = 0;
                m_cnt[i] = 0;
            end else if (e) begin
                case (m)
                    2'd1: begin
                        m_reg[i] = longint'(d);
                        m_ovf[i] = 0;
                        m_cnt[i] = 1;
                    end
                    2'd2: begin
                        v = m_reg[i] + (longint'(d) << sh);
                        if (v > 65535) begin
                            m_ovf[i] = 1;
                            m_reg[i] = (m_sat[i] != 0) ? 65535 : v % 65536;
                        end else begin
                            m_reg[i] = v;
                        end
                        if (m_cnt[i] < m_nt[i]) m_cnt[i] = m_cnt[i] + 1;
                    end
                    2'd3: begin
                        v = m_reg[i] << sh;
                        if (v > 65535) m_ovf[i] = 1;
                        m_reg[i] = v % 65536;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".a.reg"},  64'(reg_a),  64'(m_reg[0]));
        check({tag, ".a.ovf"},  64'(ovf_a),  64'(m_ovf[0]));
        check({tag, ".a.cnt"},  64'(cnt_a),  64'(m_cnt[0]));
        check({tag, ".a.done"}, 64'(done_a), 64'(m_cnt[0] == m_nt[0]));
        check({tag, ".b.reg"},  64'(reg_b),  64'(m_reg[1]));
        check({tag, ".b.ovf"},  64'(ovf_b),  64'(m_ovf[1]));
        check({tag, ".b.cnt"},  64'(cnt_b),  64'(m_cnt[1]));
        check({tag, ".b.done"}, 64'(done_b), 64'(m_cnt[1] == m_nt[1]));
    endtask

    task automatic step(input string tag, input logic s, input logic e, input logic [1:0] m,
                        input logic [3:0] sh, input logic [15:0] d);
        sclr    = s;
        clk_ena = e;
        mode    = m;
        shamt   = sh;
        datain  = d;
        model_update(s, e, m, sh, d);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        sclr    = 1'b1;
        clk_ena = 1'b0;
        mode    = 2'd0;
        shamt   = '0;
        datain  = '0;
        m_reg   = '{0, 0};
        m_ovf   = '{0, 0};
        m_cnt   = '{0, 0};
        @(negedge clk);

        // Reset state
        step("reset", 1'b1, 1'b0, 2'd0, 4'd0, 16'h0);
        check("reset.reg", 64'(reg_a), 64'h0);
        check("reset.done", 64'(done_b), 64'h0);

        // 0xAB * 0xCD via two shifted partial products
        step("mul.load", 1'b0, 1'b1, 2'd1, 4'd7, 16'h08AF);
        step("mul.acc",  1'b0, 1'b1, 2'd2, 4'd4, 16'h0804);
        check("mul.reg", 64'(reg_b), 64'h88EF);
        check("mul.cnt", 64'(cnt_b), 64'd2);
        check("mul.done", 64'(done_b), 64'd1);
        check("mul.ovf", 64'(ovf_b), 64'd0);

        // Carry-out: wrap on A, clamp on B; LOAD clears ovf
        step("carry.load", 1'b0, 1'b1, 2'd1, 4'd0, 16'hFFFF);
        step("carry.acc",  1'b0, 1'b1, 2'd2, 4'd0, 16'h0001);
        check("carry.wrap", 64'(reg_a), 64'h0000);
        check("carry.sat",  64'(reg_b), 64'hFFFF);
        check("carry.ovf",  64'(ovf_a), 64'd1);
        step("carry.reload", 1'b0, 1'b1, 2'd1, 4'd0, 16'h0003);
        check("carry.reload.ovf", 64'(ovf_a), 64'd0);

        // Shift-out overflow; shift by 15
        step("shift.load", 1'b0, 1'b1, 2'd1, 4'd0, 16'h8001);
        step("shift.1",    1'b0, 1'b1, 2'd3, 4'd1, 16'hFFFF);
        check("shift.1.reg", 64'(reg_a), 64'h0002);
        check("shift.1.ovf", 64'(ovf_a), 64'd1);
        step("shift.15",   1'b0, 1'b1, 2'd3, 4'd15, 16'h0);
        check("shift.15.reg", 64'(reg_a), 64'h0000);
        check("shift.15.cnt", 64'(cnt_a), 64'd1);

        // clk_ena low holds everything
        step("ena.load", 1'b0, 1'b1, 2'd1, 4'd0, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step("ena.hold", 1'b0, 1'b0, 2'd2, 4'd0, 16'h1111);
            check("ena.reg", 64'(reg_a), 64'h1234);
        end

        // Term counter saturation (A: NUM_TERMS=4)
        step("terms.load", 1'b0, 1'b1, 2'd1, 4'd0, 16'd1);
        for (int i = 0; i < 5; i++) begin
            step("terms.acc", 1'b0, 1'b1, 2'd2, 4'd0, 16'd1);
            check("terms.done", 64'(done_a), 64'(i >= 2));
        end
        check("terms.reg", 64'(reg_a), 64'd6);
        check("terms.cnt", 64'(cnt_a), 64'd4);

        // sclr beats clk_ena=0 and mode=LOAD
        step("sclr.mid", 1'b1, 1'b0, 2'd1, 4'd0, 16'hBEEF);
        check("sclr.reg", 64'(reg_a), 64'h0);
        check("sclr.cnt", 64'(cnt_a), 64'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic       s, e;
            logic [1:0] m;
            logic [3:0] sh;
            logic [15:0] d;
            s  = ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 7) != 0);
            m  = 2'($urandom_range(0, 3));
            sh = 4'($urandom_range(0, 15));
            d  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            step("rand", s, e, m, sh, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
